// File: rtl/led_pkg.sv
// Shared mode encoding and field widths for the LED pattern generator.
// No logic here; latency and backpressure are defined by the modules that import it.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } led_mode_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode, phase, burst countdown; led/busy registered, one cycle after load or tick.
// No backpressure: a load always wins over the tick advance in the same cycle.
module led_channel
    import led_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [1:0]       mode_i,
    input  logic [PW-1:0]    period_i,
    input  logic [PW-1:0]    on_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             led_o,
    output logic             busy_o
);

    led_mode_e        mode_q, mode_d;
    logic [PW-1:0]    period_q, period_d;
    logic [PW-1:0]    on_q, on_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             led_q, led_d;
    logic             wrap;

    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        on_d     = on_q;
        phase_d  = phase_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        wrap     = (phase_q == (period_q - PW'(1)));

        if (load_i) begin
            mode_d   = led_mode_e'(mode_i);
            period_d = (period_i == '0) ? PW'(1) : period_i;
            on_d     = on_i;
            phase_d  = '0;
            rem_d    = count_i;
            busy_d   = (mode_d == MODE_BURST) && (count_i != '0);
            // An empty burst has nothing to play, so it collapses straight to OFF.
            if ((mode_d == MODE_BURST) && (count_i == '0)) begin
                mode_d = MODE_OFF;
            end
        end else if (tick_i) begin
            phase_d = wrap ? '0 : (phase_q + PW'(1));
            if ((mode_q == MODE_BURST) && wrap) begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    mode_d = MODE_OFF;
                    busy_d = 1'b0;
                end
            end
        end

        // Drive from next-state so led tracks the new phase/mode in the same edge.
        case (mode_d)
            MODE_OFF: led_d = 1'b0;
            MODE_ON:  led_d = 1'b1;
            default:  led_d = (phase_d < on_d);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q   <= MODE_OFF;
            period_q <= PW'(1);
            on_q     <= '0;
            phase_q  <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            on_q     <= on_d;
            phase_q  <= phase_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, one-deep config staging, N_CH channels.
// Config lands at the first tick after accept, led one cycle later; cfg_ready stays low while a write is staged.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ  = 27000000,
    parameter int TICK_HZ = 1000,
    parameter int N_CH    = 3,
    parameter int PW      = 16,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [PW-1:0]    cfg_period,
    input  logic [PW-1:0]    cfg_on,
    input  logic [CNT_W-1:0] cfg_count,
    output logic [N_CH-1:0]  led,
    output logic [N_CH-1:0]  busy,
    output logic             tick
);

    localparam int DIV_RAW = CLK_HZ / TICK_HZ;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic [CH_W-1:0]  st_ch_q, st_ch_d;
    logic [1:0]       st_mode_q, st_mode_d;
    logic [PW-1:0]    st_period_q, st_period_d;
    logic [PW-1:0]    st_on_q, st_on_d;
    logic [CNT_W-1:0] st_count_q, st_count_d;
    logic             accept;
    logic             apply;

    assign accept = cfg_valid && !pend_q;
    // Only a write staged before this tick applies; accept and apply are mutually exclusive.
    assign apply  = tick_q && pend_q;

    always_comb begin
        presc_d     = (presc_q == DW'(DIV - 1)) ? '0 : (presc_q + DW'(1));
        tick_d      = (presc_d == DW'(DIV - 1));
        pend_d      = pend_q;
        st_ch_d     = st_ch_q;
        st_mode_d   = st_mode_q;
        st_period_d = st_period_q;
        st_on_d     = st_on_q;
        st_count_d  = st_count_q;
        if (accept) begin
            pend_d      = 1'b1;
            st_ch_d     = cfg_ch;
            st_mode_d   = cfg_mode;
            st_period_d = cfg_period;
            st_on_d     = cfg_on;
            st_count_d  = cfg_count;
        end else if (apply) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            pend_q      <= 1'b0;
            st_ch_q     <= '0;
            st_mode_q   <= MODE_OFF;
            st_period_q <= '0;
            st_on_q     <= '0;
            st_count_q  <= '0;
        end else begin
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
            st_ch_q     <= st_ch_d;
            st_mode_q   <= st_mode_d;
            st_period_q <= st_period_d;
            st_on_q     <= st_on_d;
            st_count_q  <= st_count_d;
        end
    end

    assign cfg_ready = !pend_q;
    assign tick      = tick_q;

    // Out-of-range channel numbers match no instance, so the apply is a no-op.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_channel #(
            .PW(PW)
        ) u_ch (
            .clk_i    (sys_clk),
            .rst_i    (sys_rst),
            .tick_i   (tick_q),
            .load_i   (apply && (st_ch_q == CH_W'(i))),
            .mode_i   (st_mode_q),
            .period_i (st_period_q),
            .on_i     (st_on_q),
            .count_i  (st_count_q),
            .led_o    (led[i]),
            .busy_o   (busy[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen at DIV=10: per-cycle led/busy expectations are queued when a config
// is applied and popped against the DUT each cycle; single-point checks cover ready, tick and reset.
module tb_led_pattern_gen;
    import led_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_period;
    logic [15:0] cfg_on;
    logic [7:0]  cfg_count;
    logic [2:0]  led;
    logic [2:0]  busy;
    logic        tick;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [2:0] led_exp;
        logic [2:0] busy_exp;
        logic [2:0] mask;
    } exp_t;
    exp_t sbq[$];

    led_pattern_gen #(
        .CLK_HZ(1000), .TICK_HZ(100), .N_CH(3), .PW(16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on(cfg_on),
        .cfg_count(cfg_count), .led(led), .busy(busy), .tick(tick)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] l, input logic [2:0] b, input logic [2:0] m);
        exp_t e;
        e.tag = tag; e.led_exp = l; e.busy_exp = b; e.mask = m;
        sbq.push_back(e);
    endtask

    task automatic drain();
        while (sbq.size() > 0) begin
            exp_t e;
            @(negedge sys_clk);
            e = sbq.pop_front();
            chk({e.tag, "_led"},  32'(led & e.mask),  32'(e.led_exp & e.mask));
            chk({e.tag, "_busy"}, 32'(busy & e.mask), 32'(e.busy_exp & e.mask));
        end
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [1:0] mode, input logic [15:0] per,
                            input logic [15:0] on_t, input logic [7:0] cnt);
        bit done = 0;
        @(negedge sys_clk);
        cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_on = on_t; cfg_count = cnt;
        cfg_valid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            if (cfg_ready) begin
                @(posedge sys_clk);
                #1 cfg_valid = 1'b0;
                done = 1;
            end else begin
                @(negedge sys_clk);
            end
        end
        if (!done) begin
            chk("write_timeout", 32'(0), 32'(1));
            cfg_valid = 1'b0;
        end
    endtask

    // Returns the number of negedges until tick is seen (0 on timeout).
    task automatic tick_gap(output int gap);
        gap = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge sys_clk);
            if (tick) begin
                gap = n;
                break;
            end
        end
        if (gap == 0) chk("tick_timeout", 32'(0), 32'(1));
    endtask

    task automatic cfg_apply(input logic [1:0] ch, input logic [1:0] mode, input logic [15:0] per,
                             input logic [15:0] on_t, input logic [7:0] cnt);
        int g;
        do_write(ch, mode, per, on_t, cnt);
        tick_gap(g);
    endtask

    initial begin
        int  gap;
        bit  seen;
        bit  done;
        sys_rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_period = '0; cfg_on = '0; cfg_count = '0;

        repeat (3) begin
            @(negedge sys_clk);
            chk("rst_led",   32'(led),       32'(0));
            chk("rst_busy",  32'(busy),      32'(0));
            chk("rst_ready", 32'(cfg_ready), 32'(1));
            chk("rst_tick",  32'(tick),      32'(0));
        end
        sys_rst = 1'b0;

        tick_gap(gap);
        tick_gap(gap); chk("tick_period_a", 32'(gap), 32'(10));
        tick_gap(gap); chk("tick_period_b", 32'(gap), 32'(10));
        chk("idle_led",   32'(led),       32'(0));
        chk("idle_busy",  32'(busy),      32'(0));
        chk("idle_ready", 32'(cfg_ready), 32'(1));

        // ch0 BLINK period 4, on 1: 10 cycles lit, 30 dark.
        cfg_apply(2'd0, MODE_BLINK, 16'd4, 16'd1, 8'd0);
        for (int k = 0; k < 80; k++)
            push("blink0", {2'b00, ((k / 10) % 4) == 0}, 3'b000, 3'b001);
        drain();

        // ch1 BURST period 2, on 1, count 3: 3 pulses, busy for 6 ticks.
        cfg_apply(2'd1, MODE_BURST, 16'd2, 16'd1, 8'd3);
        for (int k = 0; k < 80; k++)
            push("burst1", {1'b0, (k / 10) < 6 && ((k / 10) % 2) == 0, 1'b0},
                 {1'b0, (k / 10) < 6, 1'b0}, 3'b010);
        drain();

        // Back-to-back: ch0 ON, then ch2 ON held against a low cfg_ready.
        do_write(2'd0, MODE_ON, 16'd4, 16'd1, 8'd0);
        cfg_ch = 2'd2; cfg_mode = MODE_ON; cfg_valid = 1'b1;
        seen = 0; done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge sys_clk);
            chk("bb_ready", 32'(cfg_ready), 32'(seen));
            if (seen) begin
                chk("bb_led0_new", 32'(led[0]), 32'(1));
                chk("bb_led2_old", 32'(led[2]), 32'(0));
                done = 1;
            end else if (tick) begin
                seen = 1;
            end
        end
        if (!done) chk("bb_timeout", 32'(0), 32'(1));
        @(posedge sys_clk);
        #1 cfg_valid = 1'b0;
        // Second write accepted the cycle after the first tick; it applies one tick period later.
        tick_gap(gap); chk("bb_second_tick", 32'(gap), 32'(9));
        chk("bb_led2_at_tick", 32'(led[2]), 32'(0));
        @(negedge sys_clk);
        chk("bb_led2_applied", 32'(led[2]),    32'(1));
        chk("bb_ready_after",  32'(cfg_ready), 32'(1));

        // Period 0 / on 0 is dark; on beyond period is lit.
        cfg_apply(2'd2, MODE_BLINK, 16'd0, 16'd0, 8'd0);
        chk("p0_led2_at_tick", 32'(led[2]), 32'(1));
        for (int k = 0; k < 30; k++) push("p0on0", 3'b000, 3'b000, 3'b100);
        drain();
        cfg_apply(2'd2, MODE_BLINK, 16'd4, 16'd5, 8'd0);
        for (int k = 0; k < 50; k++) push("on5p4", 3'b100, 3'b000, 3'b100);
        drain();

        // Channel 3 does not exist: nothing may change.
        cfg_apply(2'd3, MODE_ON, 16'd2, 16'd1, 8'd4);
        for (int k = 0; k < 30; k++) push("ch3_noop", 3'b101, 3'b000, 3'b111);
        drain();

        // BURST with count 0 behaves as OFF with busy never set.
        cfg_apply(2'd1, MODE_ON, 16'd2, 16'd1, 8'd0);
        cfg_apply(2'd1, MODE_BURST, 16'd2, 16'd1, 8'd0);
        for (int k = 0; k < 30; k++) push("burst_cnt0", 3'b000, 3'b000, 3'b010);
        drain();

        // Reconfigure mid-burst: busy drops with the new mode.
        cfg_apply(2'd1, MODE_BURST, 16'd4, 16'd4, 8'd10);
        for (int k = 0; k < 20; k++) push("burst_long", 3'b010, 3'b010, 3'b010);
        drain();
        cfg_apply(2'd1, MODE_BLINK, 16'd2, 16'd1, 8'd0);
        chk("abort_busy_at_tick", 32'(busy[1]), 32'(1));
        for (int k = 0; k < 20; k++) push("abort", {1'b0, k < 10, 1'b0}, 3'b000, 3'b010);
        drain();

        // Reset mid-burst with a write staged: everything cleared, staged write lost.
        cfg_apply(2'd1, MODE_BURST, 16'd2, 16'd2, 8'd5);
        for (int k = 0; k < 15; k++) push("burst_pre_rst", 3'b010, 3'b010, 3'b010);
        drain();
        do_write(2'd2, MODE_ON, 16'd1, 16'd1, 8'd0);
        chk("staged_ready", 32'(cfg_ready), 32'(0));
        sys_rst = 1'b1;
        repeat (2) begin
            @(negedge sys_clk);
            chk("midrst_led",   32'(led),       32'(0));
            chk("midrst_busy",  32'(busy),      32'(0));
            chk("midrst_ready", 32'(cfg_ready), 32'(1));
            chk("midrst_tick",  32'(tick),      32'(0));
        end
        sys_rst = 1'b0;
        for (int k = 0; k < 30; k++) push("post_rst", 3'b000, 3'b000, 3'b111);
        drain();
        chk("post_rst_ready", 32'(cfg_ready), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
